// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for an RV32I-style datapath: fetch/decode/execute/memory/writeback
// sequencing with handshake timeouts, a sticky trap state and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned RET_CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 ir_write,
  input  logic                 dmem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 branch,
  output logic                 jump,
  output logic                 pc_write,
  output logic [1:0]           alu_op,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [RET_CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_RSV6   = 3'd6,
    S_RSV7   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    C_NONE    = 2'b00,
    C_ILLEGAL = 2'b01,
    C_IMEM_TO = 2'b10,
    C_DMEM_TO = 2'b11
  } cause_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int unsigned WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  state_e               state_q, state_d;
  logic [6:0]           op_q, op_d;
  cause_e               cause_q, cause_d;
  logic [WCW-1:0]       wait_q, wait_d;
  logic [RET_CNT_W-1:0] ret_q, ret_d;

  logic imem_req_c, ir_write_c, mem_read_c, mem_write_c, alu_src_c, mem_to_reg_c;
  logic reg_write_c, branch_c, jump_c, pc_write_c;
  logic [1:0] alu_op_c;
  logic wait_expired;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IARITH, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  // Only consulted when the ready input is low, so ready wins on the limit cycle.
  assign wait_expired = (WAIT_LIMIT != 0) && (wait_q == WLAST);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cause_d      = cause_q;
    wait_d       = wait_q;
    imem_req_c   = 1'b0;
    ir_write_c   = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    alu_src_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    branch_c     = 1'b0;
    jump_c       = 1'b0;
    pc_write_c   = 1'b0;
    alu_op_c     = 2'b00;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = C_IMEM_TO;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (is_legal(opcode)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = C_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R: begin
            alu_op_c = 2'b10;
            state_d  = S_WB;
          end
          OP_IARITH: begin
            alu_src_c = 1'b1;
            state_d   = S_WB;
          end
          OP_LUI, OP_AUIPC: begin
            alu_op_c  = 2'b11;
            alu_src_c = 1'b1;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_op_c  = 2'b11;
            alu_src_c = 1'b1;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            alu_op_c   = 2'b01;
            branch_c   = 1'b1;
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            alu_src_c   = (op_q == OP_JALR);
            jump_c      = 1'b1;
            reg_write_c = 1'b1;
            pc_write_c  = 1'b1;
            state_d     = S_FETCH;
          end
          default: begin
            state_d = S_TRAP;
            cause_d = C_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        alu_op_c    = 2'b11;
        alu_src_c   = 1'b1;
        mem_read_c  = (op_q == OP_LOAD);
        mem_write_c = (op_q == OP_STORE);
        if (dmem_ready) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = C_DMEM_TO;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        pc_write_c   = 1'b1;
        mem_to_reg_c = (op_q == OP_LOAD);
        state_d      = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
        cause_d = C_ILLEGAL;
      end
    endcase

    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready)) begin
      wait_d = wait_q + WCW'(1);
    end
  end

  assign ret_d = pc_write_c ? ret_q + RET_CNT_W'(1) : ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cause_q <= C_NONE;
      wait_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
    end
  end

  // State sits at FETCH during reset, so strobes are gated by rst_n to read all-zero.
  assign imem_req   = rst_n & imem_req_c;
  assign ir_write   = rst_n & ir_write_c;
  assign mem_read   = rst_n & mem_read_c;
  assign mem_write  = rst_n & mem_write_c;
  assign alu_src    = rst_n & alu_src_c;
  assign mem_to_reg = rst_n & mem_to_reg_c;
  assign reg_write  = rst_n & reg_write_c;
  assign branch     = rst_n & branch_c;
  assign jump       = rst_n & jump_c;
  assign pc_write   = rst_n & pc_write_c;
  assign alu_op     = rst_n ? alu_op_c : 2'b00;
  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: expected per-cycle output vectors are queued as each instruction is issued
// and popped against the DUT outputs mid-cycle.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, ir_write, mem_read, mem_write, alu_src, mem_to_reg;
  logic       reg_write, branch, jump, pc_write, trap;
  logic [1:0] alu_op, trap_cause;
  logic [2:0] state;
  logic [2:0] retired;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       pc_write;
    logic [1:0] alu_op;
    logic       trap;
    logic [1:0] cause;
    logic [2:0] ret;
  } obs_t;

  obs_t       obs;
  obs_t       expq[$];
  logic [2:0] ret_m = '0;
  int         n_chk = 0;
  int         n_fail = 0;

  multicycle_control_unit #(.WAIT_LIMIT(4), .RET_CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_write(ir_write),
    .dmem_ready(dmem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .branch(branch), .jump(jump), .pc_write(pc_write), .alu_op(alu_op),
    .state(state), .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  assign obs = {state, imem_req, ir_write, mem_read, mem_write, alu_src, mem_to_reg,
                reg_write, branch, jump, pc_write, alu_op, trap, trap_cause, retired};

  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e     = '0;
    e.st  = st;
    e.ret = ret_m;
    return e;
  endfunction

  function automatic obs_t fetch_e(input logic rdy);
    obs_t e;
    e          = base(3'd0);
    e.imem_req = 1'b1;
    e.ir_write = rdy;
    return e;
  endfunction

  function automatic obs_t trap_e(input logic [1:0] c);
    obs_t e;
    e       = base(3'd5);
    e.trap  = 1'b1;
    e.cause = c;
    return e;
  endfunction

  // Full expected sequence of one instruction with zero-wait fetch and mwait dmem stalls.
  task automatic push_instr(input logic [6:0] opc, input int unsigned mwait);
    obs_t e;
    logic to_mem, to_wb;
    to_mem = 1'b0;
    to_wb  = 1'b0;
    expq.push_back(fetch_e(1'b1));
    expq.push_back(base(3'd1));
    e = base(3'd2);
    case (opc)
      OP_R:             begin e.alu_op = 2'b10; to_wb = 1'b1; end
      OP_IARITH:        begin e.alu_src = 1'b1; to_wb = 1'b1; end
      OP_LUI, OP_AUIPC: begin e.alu_op = 2'b11; e.alu_src = 1'b1; to_wb = 1'b1; end
      OP_LOAD, OP_STORE: begin e.alu_op = 2'b11; e.alu_src = 1'b1; to_mem = 1'b1; end
      OP_BRANCH:        begin e.alu_op = 2'b01; e.branch = 1'b1; e.pc_write = 1'b1; end
      OP_JAL:           begin e.jump = 1'b1; e.reg_write = 1'b1; e.pc_write = 1'b1; end
      OP_JALR: begin
        e.alu_src = 1'b1; e.jump = 1'b1; e.reg_write = 1'b1; e.pc_write = 1'b1;
      end
      default: ;
    endcase
    expq.push_back(e);
    if (e.pc_write) ret_m = ret_m + 3'd1;
    if (to_mem) begin
      for (int unsigned i = 0; i <= mwait; i++) begin
        e           = base(3'd3);
        e.alu_op    = 2'b11;
        e.alu_src   = 1'b1;
        e.mem_read  = (opc == OP_LOAD);
        e.mem_write = (opc == OP_STORE);
        e.pc_write  = (opc == OP_STORE) && (i == mwait);
        expq.push_back(e);
      end
      if (opc == OP_STORE) ret_m = ret_m + 3'd1;
      else to_wb = 1'b1;
    end
    if (to_wb) begin
      e            = base(3'd4);
      e.reg_write  = 1'b1;
      e.pc_write   = 1'b1;
      e.mem_to_reg = (opc == OP_LOAD);
      expq.push_back(e);
      ret_m = ret_m + 3'd1;
    end
  endtask

  task automatic step(input logic ir, input logic dr, input logic [6:0] opc, input string nm);
    obs_t e;
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ready = ir;
    dmem_ready = dr;
    opcode     = opc;
    #1;
    n_chk++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", nm, obs);
    end else begin
      e = expq.pop_front();
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h expected %h", nm, $time, obs, e);
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] opc, input int unsigned mwait, input string nm);
    int unsigned mc;
    logic        dr;
    mc = 0;
    push_instr(opc, mwait);
    while (expq.size() != 0) begin
      dr = 1'b1;
      if (expq[0].st == 3'd3) begin
        dr = (mc >= mwait);
        mc++;
      end
      step(1'b1, dr, opc, nm);
    end
  endtask

  task automatic do_reset(input string nm);
    obs_t e;
    @(negedge clk);
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    ret_m = '0;
    expq.delete();
    e = base(3'd0);
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, obs, e);
    end
  endtask

  task automatic test_reset();
    obs_t e;
    do_reset("reset_async");
    @(posedge clk);
    #1;
    e = base(3'd0);
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_rtype_load();
    run_instr(OP_R, 0, "rtype");
    run_instr(OP_LOAD, 3, "load_wait3");
  endtask

  task automatic test_store_jal_mix();
    do_reset("reset_b");
    run_instr(OP_STORE, 0, "store");
    run_instr(OP_JAL, 0, "jal");
    run_instr(OP_R, 0, "rtype_after_jal");
    run_instr(OP_IARITH, 0, "iarith");
    run_instr(OP_LUI, 0, "lui");
    run_instr(OP_AUIPC, 0, "auipc");
    run_instr(OP_JALR, 0, "jalr");
  endtask

  task automatic test_branch_wrap_reset_in_mem();
    obs_t e;
    do_reset("reset_c");
    for (int i = 0; i < 9; i++) run_instr(OP_BRANCH, 0, "branch_wrap");
    push_instr(OP_LOAD, 5);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, OP_LOAD, "load_pre_reset");
    #1;
    rst_n = 1'b0;
    #1;
    expq.delete();
    ret_m = '0;
    e = base(3'd0);
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_in_mem: got %h expected %h", obs, e);
    end
    run_instr(OP_R, 0, "rtype_after_reset");
  endtask

  task automatic test_imem_timeout();
    do_reset("reset_d");
    for (int i = 0; i < 4; i++) expq.push_back(fetch_e(1'b0));
    for (int i = 0; i < 3; i++) expq.push_back(trap_e(2'b10));
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, OP_R, "imem_timeout");
    do_reset("reset_e");
    for (int i = 0; i < 3; i++) expq.push_back(fetch_e(1'b0));
    expq.push_back(fetch_e(1'b1));
    expq.push_back(base(3'd1));
    for (int i = 0; i < 5; i++) step(i >= 3, 1'b1, OP_R, "imem_ready_at_limit");
  endtask

  task automatic test_dmem_timeout();
    obs_t e;
    do_reset("reset_f");
    expq.push_back(fetch_e(1'b1));
    expq.push_back(base(3'd1));
    e = base(3'd2); e.alu_op = 2'b11; e.alu_src = 1'b1;
    expq.push_back(e);
    e = base(3'd3); e.alu_op = 2'b11; e.alu_src = 1'b1; e.mem_write = 1'b1;
    for (int i = 0; i < 4; i++) expq.push_back(e);
    for (int i = 0; i < 2; i++) expq.push_back(trap_e(2'b11));
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, OP_STORE, "dmem_timeout");
  endtask

  task automatic test_illegal();
    do_reset("reset_g");
    expq.push_back(fetch_e(1'b1));
    expq.push_back(base(3'd1));
    for (int i = 0; i < 20; i++) expq.push_back(trap_e(2'b01));
    step(1'b1, 1'b1, OP_BAD, "illegal_fetch");
    step(1'b0, 1'b1, OP_BAD, "illegal_decode");
    for (int i = 0; i < 20; i++) step(i[0], ~i[0], OP_R, "illegal_trap_hold");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype_load();
    test_store_jal_mix();
    test_branch_wrap_reset_in_mem();
    test_imem_timeout();
    test_dmem_timeout();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
